// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    BLANK_A = 2'd0,
    DIG1    = 2'd1,
    BLANK_B = 2'd2,
    DIG10   = 2'd3
  } scan_state_e;

  localparam int unsigned SEG_W = 8;

  localparam logic [SEG_W-1:0] SEG_DASH  = 8'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Lit pattern {dp,g,f,e,d,c,b,a} per 4-bit value; entry 15 first, entry 0 last.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    SEG_BLANK,
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
    8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [SEG_W-1:0] seg_lookup(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational 4-bit value to seven-segment lit pattern (dp always off).
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0]       value,
  output logic [SEG_W-1:0] lit_c
);

  always_comb begin
    lit_c = seg_lookup(value);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Two-digit multiplexed display scanner with blanking gaps, frame-atomic
// source selection (dice digits or raw override patterns) and pin polarity.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [3:0]       digit1,
  input  logic [3:0]       digit10,
  input  logic             ovr_valid,
  input  logic [SEG_W-1:0] ovr_seg1,
  input  logic [SEG_W-1:0] ovr_seg10,
  input  logic             cfg_com_pol,
  input  logic             cfg_seg_pol,
  output logic [SEG_W-1:0] seg_out,
  output logic             com1_out,
  output logic             com10_out,
  output logic [1:0]       com_oe,
  output logic             src_ovr
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] ST_BLANK_A = 2'(BLANK_A);
  localparam logic [1:0] ST_DIG1    = 2'(DIG1);
  localparam logic [1:0] ST_BLANK_B = 2'(BLANK_B);
  localparam logic [1:0] ST_DIG10   = 2'(DIG10);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             phase_last;
  logic             frame_start;

  logic [3:0]       snap_d1;
  logic [3:0]       snap_d10;
  logic [3:0]       enc_value;
  logic [SEG_W-1:0] enc_lit;
  logic [SEG_W-1:0] lit;
  logic             suppress;

  logic [SEG_W-1:0] seg_nxt;
  logic             com1_nxt;
  logic             com10_nxt;

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_BLANK_A;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: fixed phase lengths, counter cleared on each transition.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_W'(1);
    phase_last = 1'b0;
    if (!ena) begin
      state_nxt = ST_BLANK_A;
      cnt_nxt   = '0;
    end else begin
      if ((state == ST_DIG1) || (state == ST_DIG10)) begin
        phase_last = (cnt == DIV_LAST);
      end else begin
        phase_last = (cnt == BLANK_LAST);
      end
      if (phase_last) begin
        cnt_nxt = '0;
        case (state)
          ST_BLANK_A: state_nxt = ST_DIG1;
          ST_DIG1:    state_nxt = ST_BLANK_B;
          ST_BLANK_B: state_nxt = ST_DIG10;
          ST_DIG10:   state_nxt = ST_BLANK_A;
          default:    state_nxt = ST_BLANK_A;
        endcase
      end
    end
  end

  // The first BLANK_A cycle of every frame latches source and digits for the whole frame.
  assign frame_start = (state == ST_BLANK_A) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_ovr  <= 1'b0;
      snap_d1  <= '0;
      snap_d10 <= '0;
    end else if (frame_start) begin
      src_ovr  <= ovr_valid;
      snap_d1  <= digit1;
      snap_d10 <= digit10;
    end
  end

  assign enc_value = (state == ST_DIG10) ? snap_d10 : snap_d1;

  seg7_encode u_seg7_encode (
    .value (enc_value),
    .lit_c (enc_lit)
  );

  // Output next-values; blanking is the default so commons can never overlap.
  always_comb begin
    seg_nxt   = {SEG_W{~cfg_seg_pol}};
    com1_nxt  = ~cfg_com_pol;
    com10_nxt = ~cfg_com_pol;
    lit       = enc_lit;
    suppress  = !src_ovr && (snap_d10 == 4'd0);
    if (src_ovr) begin
      lit = (state == ST_DIG10) ? ovr_seg10 : ovr_seg1;
    end
    if (ena) begin
      case (state)
        ST_DIG1: begin
          com1_nxt = cfg_com_pol;
          seg_nxt  = cfg_seg_pol ? lit : ~lit;
        end
        ST_DIG10: begin
          if (!suppress) begin
            com10_nxt = cfg_com_pol;
            seg_nxt   = cfg_seg_pol ? lit : ~lit;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_out   <= '0;
      com1_out  <= 1'b0;
      com10_out <= 1'b0;
      com_oe    <= 2'b00;
    end else begin
      seg_out   <= seg_nxt;
      com1_out  <= com1_nxt;
      com10_out <= com10_nxt;
      com_oe    <= 2'b11;
    end
  end

endmodule
